comparador_serial: RTL and testbench

Parametrised, sequential successor to the 2-bit equality comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, and reports equal, less-than or greater-than, in unsigned or two's-complement mode. Uses a start/ready/done handshake and holds its result registers. It sits beside the existing gate-level blocks as the team's generic magnitude comparator for datapaths wider than one cycle's worth of logic.

---
 rtl/comparador_pkg.sv | 31 +++
 rtl/comparador_chunk.sv | 29 ++
 rtl/comparador_serial.sv | 172 +++++++++++++++++
 tb/tb_comparador_serial.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared types and helpers for the serial magnitude comparator.
//   estado_t      : controller states (IDLE, COMPARE, DONE)
//   calc_nchunk() : number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width()   : chunk-counter width for a given slice count
//   CNT_W         : counter width for the default 16/4 configuration
// -----------------------------------------------------------------------------
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } estado_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice operand still needs a one-bit counter.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    localparam int CNT_W = cnt_width(calc_nchunk(DEF_WIDTH, DEF_CHUNK));

endpackage

// File: rtl/comparador_chunk.sv
// -----------------------------------------------------------------------------
// comparador_chunk
// Purely combinational unsigned compare of one CHUNK-bit slice.
//   i_a, i_b    : slice of operand A / B
//   o_chunk_eq  : i_a == i_b
//   o_chunk_lt  : i_a <  i_b (unsigned)
// -----------------------------------------------------------------------------
module comparador_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_chunk_eq,
    output logic             o_chunk_lt
);

    logic [CHUNK-1:0] w_bit_diff;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign w_bit_diff[gi] = i_a[gi] ^ i_b[gi];
        end
    endgenerate

    assign o_chunk_eq = ~|w_bit_diff;
    assign o_chunk_lt = (i_a < i_b);

endmodule

// File: rtl/comparador_serial.sv
// -----------------------------------------------------------------------------
// comparador_serial
// Sequential WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB first,
// unsigned or two's-complement, with start/ready/done handshake. Result
// registers hold until the next operation completes.
//
// Optional build macro: COMPARADOR_SERIAL_EARLY_EXIT_EN
//   defined     -> leave COMPARE on the first differing chunk (latency 1..NCHUNK)
//   not defined -> always NCHUNK COMPARE cycles (constant time)
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start_i   request, accepted when start_i & ready_o
//   a_i, b_i  operands, sampled on acceptance
//   signed_i  1 = two's-complement compare, sampled on acceptance
//   ready_o   high only in IDLE
//   done_o    one-cycle pulse, results valid from this cycle
//   eq_o/lt_o/gt_o  A == B / A < B / A > B
// -----------------------------------------------------------------------------
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0]    LAST_CNT = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_param_check
            $error("comparador_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    estado_t          r_state;
    estado_t          w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_decided;
    logic             r_lt_dec;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    logic             w_chunk_eq;
    logic             w_chunk_lt;
    logic             w_chunk_diff;
    logic             w_last;
    logic             w_exit;
    logic             w_decided_now;
    logic             w_lt_now;
    logic [WIDTH-1:0] w_a_cap;
    logic [WIDTH-1:0] w_b_cap;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the datapath only ever does unsigned slice compares.
    assign w_a_cap = signed_i ? (a_i ^ MSB_MASK) : a_i;
    assign w_b_cap = signed_i ? (b_i ^ MSB_MASK) : b_i;

    comparador_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a        (r_a[WIDTH-1 -: CHUNK]),
        .i_b        (r_b[WIDTH-1 -: CHUNK]),
        .o_chunk_eq (w_chunk_eq),
        .o_chunk_lt (w_chunk_lt)
    );

    assign w_chunk_diff  = ~w_chunk_eq;
    assign w_last        = (r_cnt == LAST_CNT);
    // The first differing chunk wins; later chunks cannot override it.
    assign w_decided_now = r_decided | w_chunk_diff;
    assign w_lt_now      = r_decided ? r_lt_dec : w_chunk_lt;

`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
    assign w_exit = w_last | w_chunk_diff;
`else
    assign w_exit = w_last;
`endif

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (w_exit) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_lt_dec  <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a       <= w_a_cap;
                        r_b       <= w_b_cap;
                        r_cnt     <= '0;
                        r_decided <= 1'b0;
                        r_lt_dec  <= 1'b0;
                    end
                end
                COMPARE: begin
                    r_a       <= r_a << CHUNK;
                    r_b       <= r_b << CHUNK;
                    r_cnt     <= r_cnt + CW'(1);
                    r_decided <= w_decided_now;
                    r_lt_dec  <= w_lt_now;
                    if (w_exit) begin
                        r_eq <= ~w_decided_now;
                        r_lt <= w_decided_now & w_lt_now;
                        r_gt <= w_decided_now & ~w_lt_now;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eq_o = r_eq;
    assign lt_o = r_lt;
    assign gt_o = r_gt;

endmodule

// File: tb/tb_comparador_serial.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial
// Directed bench for comparador_serial (WIDTH=16, CHUNK=4). Expected latencies
// follow COMPARADOR_SERIAL_EARLY_EXIT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_comparador_serial;

`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        signed_i;
    logic        ready_o;
    logic        done_o;
    logic        eq_o;
    logic        lt_o;
    logic        gt_o;

    int checks_cnt;
    int fail_cnt;

    comparador_serial #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .eq_o     (eq_o),
        .lt_o     (lt_o),
        .gt_o     (gt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive a request while IDLE and step past the acceptance edge (E0).
    task automatic accept(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input bit hold);
        start_i  = 1'b1;
        a_i      = a;
        b_i      = b;
        signed_i = s;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        check("accept_ready_low", ready_o, 1'b0);
    endtask

    // Count edges after E0 until done_o is seen (bounded).
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done_o) seen = 1'b1;
        end
        if (!seen) check("done_timeout", done_o, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input int exp_lat,
                          input logic exp_eq, input logic exp_lt, input logic exp_gt);
        int lat;
        accept(a, b, s, 1'b0);
        wait_done(lat);
        $display("op %s a=%04h b=%04h signed=%0d lat=%0d eq=%0d lt=%0d gt=%0d",
                 tag, a, b, s, lat, eq_o, lt_o, gt_o);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_eq"}, eq_o, exp_eq);
        check({tag, "_lt"}, lt_o, exp_lt);
        check({tag, "_gt"}, gt_o, exp_gt);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_o, 1'b0);
        check({tag, "_ready_back"}, ready_o, 1'b1);
        check({tag, "_hold_lt"}, lt_o, exp_lt);
    endtask

    initial begin
        int lat;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        a_i        = '0;
        b_i        = '0;
        signed_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        $display("reset ready=%0d done=%0d eq=%0d lt=%0d gt=%0d", ready_o, done_o, eq_o, lt_o, gt_o);
        check("rst_ready", ready_o, 1'b1);
        check("rst_done", done_o, 1'b0);
        check("rst_eq", eq_o, 1'b0);
        check("rst_lt", lt_o, 1'b0);
        check("rst_gt", gt_o, 1'b0);

        run_op("eq",   16'h1234, 16'h1234, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        run_op("lt",   16'h1234, 16'h1235, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        run_op("uns",  16'h8000, 16'h0001, 1'b0, EARLY ? 1 : 4, 1'b0, 1'b0, 1'b1);
        run_op("sgn",  16'h8000, 16'h0001, 1'b1, EARLY ? 1 : 4, 1'b0, 1'b1, 1'b0);
        run_op("sgn2", 16'hFFFF, 16'h0001, 1'b1, EARLY ? 1 : 4, 1'b0, 1'b1, 1'b0);

        // start pulsed during COMPARE with operands that would give lt
        accept(16'h1234, 16'h1200, 1'b0, 1'b1);
        a_i = 16'h0000;
        b_i = 16'hFFFF;
        wait_done(lat);
        start_i = 1'b0;
        $display("op ignore a=1234 b=1200 lat=%0d eq=%0d lt=%0d gt=%0d", lat, eq_o, lt_o, gt_o);
        check("ign_lat", lat, EARLY ? 3 : 4);
        check("ign_gt", gt_o, 1'b1);
        check("ign_lt", lt_o, 1'b0);
        @(posedge clk); #1;
        check("ign_not_queued", ready_o, 1'b1);
        @(posedge clk); #1;
        check("ign_still_idle", ready_o, 1'b1);

        // reset at the second COMPARE cycle
        accept(16'h0001, 16'h0002, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("abort ready=%0d done=%0d eq=%0d lt=%0d gt=%0d", ready_o, done_o, eq_o, lt_o, gt_o);
        check("abort_ready", ready_o, 1'b1);
        check("abort_done", done_o, 1'b0);
        check("abort_eq", eq_o, 1'b0);
        check("abort_lt", lt_o, 1'b0);
        check("abort_gt", gt_o, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done_o, 1'b0);
        end

        // start held across two back-to-back operations
        accept(16'h0001, 16'h0002, 1'b0, 1'b1);
        wait_done(lat);
        $display("op held1 a=0001 b=0002 lat=%0d lt=%0d", lat, lt_o);
        check("held1_lat", lat, 4);
        check("held1_lt", lt_o, 1'b1);
        a_i = 16'h0003;
        b_i = 16'h0003;
        @(posedge clk); #1;
        check("held_idle_ready", ready_o, 1'b1);
        check("held_idle_lt", lt_o, 1'b1);
        @(posedge clk); #1;
        check("held_accepted", ready_o, 1'b0);
        lat = 0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #1;
                lat++;
                if (done_o) seen = 1'b1;
                else check("held_lt_hold", lt_o, 1'b1);
            end
            if (!seen) check("held2_timeout", done_o, 1'b1);
        end
        start_i = 1'b0;
        $display("op held2 a=0003 b=0003 lat=%0d eq=%0d lt=%0d", lat, eq_o, lt_o);
        check("held2_lat", lat, 4);
        check("held2_eq", eq_o, 1'b1);
        check("held2_lt", lt_o, 1'b0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
